step_counter_bank: RTL and testbench

//  Parametrised successor to the single 8-bit temp register of the stepper ASIP.

---
 rtl/step_counter_bank.sv | 187 ++++++++++++++++++
 tb/tb_step_counter_bank.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_counter_bank.sv
// -----------------------------------------------------------------------------
// step_counter_bank
//   Bank of NUM_REGS signed WIDTH-bit counters for the stepper sequencer (step
//   counts and inter-step delays). Each counter supports LOAD/INC/DEC/CLR/
//   ADD/SUB and an ARM mode. In ARM mode, the tick strobe counts the counter
//   down, and expire pulses when the counter reaches zero. Each counter has a
//   sticky signed-overflow flag. The bank can optionally saturate instead of
//   wrapping.
//
//   Handshake: op_valid qualifies op/op_addr/op_data. There is no ready. Every
//   op presented with op_valid=1 is consumed at that posedge, and its result is
//   visible on rd_data right after the edge.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   op_valid/op/op_addr/op_data   operation request (one per cycle)
//   tick                  countdown strobe for all armed counters
//   disarm[NUM_REGS]      per-counter disarm request (no expire)
//   rd_addr -> rd_data    combinational read port, 0 when out of range
//   negative/zero/positive   flags of rd_data
//   ovf/armed/expire      per-counter sticky overflow, countdown mode, and
//                         one-cycle expire pulse
// -----------------------------------------------------------------------------
module step_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                op_valid,
  input  logic [2:0]          op,
  input  logic [ADDR_W-1:0]   op_addr,
  input  logic [WIDTH-1:0]    op_data,
  input  logic                tick,
  input  logic [NUM_REGS-1:0] disarm,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic                negative,
  output logic                zero,
  output logic                positive,
  output logic [NUM_REGS-1:0] ovf,
  output logic [NUM_REGS-1:0] armed,
  output logic [NUM_REGS-1:0] expire
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_ARM  = 3'b111;

  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0]    cnt_q [NUM_REGS];
  logic [WIDTH-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] ovf_q, ovf_d;
  logic [NUM_REGS-1:0] armed_q, armed_d;
  logic [NUM_REGS-1:0] expire_q, expire_d;

  // Only one op per cycle, so a single shared adder serves the whole bank.
  logic [WIDTH-1:0]    sel_cnt;
  logic [WIDTH-1:0]    operand;
  logic [WIDTH-1:0]    raw;
  logic [WIDTH-1:0]    arith_res;
  logic                is_sub;
  logic                arith_ovf;
  logic [NUM_REGS-1:0] hit;

  // Decode the target counter. An op_addr beyond NUM_REGS matches nothing,
  // so the op has no effect.
  always_comb begin
    sel_cnt = '0;
    hit     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (op_addr == ADDR_W'(i)) begin
        sel_cnt = cnt_q[i];
        hit[i]  = op_valid && (op != OP_NOP);
      end
    end
  end

  always_comb begin
    operand = ((op == OP_ADD) || (op == OP_SUB)) ? op_data : ONE;
    is_sub  = (op == OP_DEC) || (op == OP_SUB);
    raw     = is_sub ? (sel_cnt - operand) : (sel_cnt + operand);
    // Signed overflow happens when the effective operands share a sign and the
    // result's sign differs. For a subtraction, the operand's sign is inverted.
    if (is_sub)
      arith_ovf = (sel_cnt[WIDTH-1] != operand[WIDTH-1]) && (raw[WIDTH-1] != sel_cnt[WIDTH-1]);
    else
      arith_ovf = (sel_cnt[WIDTH-1] == operand[WIDTH-1]) && (raw[WIDTH-1] != sel_cnt[WIDTH-1]);
    // On overflow, the true result lies beyond the limit on the side of the
    // original value's sign.
    if ((SATURATE != 0) && arith_ovf)
      arith_res = sel_cnt[WIDTH-1] ? S_MIN : S_MAX;
    else
      arith_res = raw;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i]    = cnt_q[i];
      ovf_d[i]    = ovf_q[i];
      armed_d[i]  = armed_q[i];
      expire_d[i] = 1'b0;
      if (hit[i]) begin
        // An op on this counter wins over a tick in the same cycle.
        case (op)
          OP_LOAD: begin
            cnt_d[i] = op_data;
            ovf_d[i] = 1'b0;
            if (op_data == '0) armed_d[i] = 1'b0;
          end
          OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
            cnt_d[i] = arith_res;
            if (arith_ovf) ovf_d[i] = 1'b1;
            // An arithmetic result of zero ends the countdown silently.
            if (arith_res == '0) armed_d[i] = 1'b0;
          end
          OP_CLR: begin
            cnt_d[i]   = '0;
            ovf_d[i]   = 1'b0;
            armed_d[i] = 1'b0;
          end
          OP_ARM: begin
            // Arming a counter that is already at zero expires it immediately.
            if (cnt_q[i] == '0) begin
              armed_d[i]  = 1'b0;
              expire_d[i] = 1'b1;
            end else begin
              armed_d[i]  = 1'b1;
            end
          end
          default: ;
        endcase
        // ARM beats disarm; any other op still honours disarm.
        if ((op != OP_ARM) && disarm[i]) armed_d[i] = 1'b0;
      end else if (disarm[i]) begin
        armed_d[i] = 1'b0;
      end else if (tick && armed_q[i]) begin
        // An armed counter is never zero, so this unsigned decrement cannot
        // wrap.
        cnt_d[i] = cnt_q[i] - ONE;
        if (cnt_q[i] == ONE) begin
          armed_d[i]  = 1'b0;
          expire_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      ovf_q    <= '0;
      armed_q  <= '0;
      expire_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      ovf_q    <= ovf_d;
      armed_q  <= armed_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = cnt_q[i];
    end
  end

  assign negative = rd_data[WIDTH-1];
  assign zero     = (rd_data == '0);
  assign positive = ~zero & ~negative;
  assign ovf      = ovf_q;
  assign armed    = armed_q;
  assign expire   = expire_q;

endmodule

// File: tb/tb_step_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_step_counter_bank
//   Three instances driven by identical stimulus:
//     dut 0: WIDTH=8, NUM_REGS=4, SATURATE=0
//     dut 1: WIDTH=8, NUM_REGS=4, SATURATE=1
//     dut 2: WIDTH=8, NUM_REGS=3, SATURATE=0
//   Directed scenarios check constants. The random scenario checks every output
//   of every instance against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_step_counter_bank;

  localparam int NDUT = 3;
  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, INC = 3'd2, DEC = 3'd3;
  localparam logic [2:0] CLR = 3'd4, ADD = 3'd5, SUB = 3'd6, ARM = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       op_valid;
  logic [2:0] op;
  logic [1:0] op_addr;
  logic [7:0] op_data;
  logic       tick;
  logic [3:0] disarm;
  logic [1:0] rd_addr;

  logic [7:0] rd0, rd1, rd2;
  logic       n0, n1, n2, z0, z1, z2, p0, p1, p2;
  logic [3:0] ovf0, ovf1, arm0, arm1, exp0, exp1;
  logic [2:0] ovf2, arm2, exp2;

  logic [7:0] rd_v   [NDUT];
  logic       neg_v  [NDUT];
  logic       zero_v [NDUT];
  logic       pos_v  [NDUT];
  logic [3:0] ovf_v  [NDUT];
  logic [3:0] arm_v  [NDUT];
  logic [3:0] exp_v  [NDUT];

  step_counter_bank #(.WIDTH(8), .NUM_REGS(4), .ADDR_W(2), .SATURATE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op), .op_addr(op_addr),
    .op_data(op_data), .tick(tick), .disarm(disarm), .rd_addr(rd_addr),
    .rd_data(rd0), .negative(n0), .zero(z0), .positive(p0),
    .ovf(ovf0), .armed(arm0), .expire(exp0));

  step_counter_bank #(.WIDTH(8), .NUM_REGS(4), .ADDR_W(2), .SATURATE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op), .op_addr(op_addr),
    .op_data(op_data), .tick(tick), .disarm(disarm), .rd_addr(rd_addr),
    .rd_data(rd1), .negative(n1), .zero(z1), .positive(p1),
    .ovf(ovf1), .armed(arm1), .expire(exp1));

  step_counter_bank #(.WIDTH(8), .NUM_REGS(3), .ADDR_W(2), .SATURATE(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op), .op_addr(op_addr),
    .op_data(op_data), .tick(tick), .disarm(disarm[2:0]), .rd_addr(rd_addr),
    .rd_data(rd2), .negative(n2), .zero(z2), .positive(p2),
    .ovf(ovf2), .armed(arm2), .expire(exp2));

  assign rd_v[0] = rd0;  assign rd_v[1] = rd1;  assign rd_v[2] = rd2;
  assign neg_v[0] = n0;  assign neg_v[1] = n1;  assign neg_v[2] = n2;
  assign zero_v[0] = z0; assign zero_v[1] = z1; assign zero_v[2] = z2;
  assign pos_v[0] = p0;  assign pos_v[1] = p1;  assign pos_v[2] = p2;
  assign ovf_v[0] = ovf0; assign ovf_v[1] = ovf1; assign ovf_v[2] = {1'b0, ovf2};
  assign arm_v[0] = arm0; assign arm_v[1] = arm1; assign arm_v[2] = {1'b0, arm2};
  assign exp_v[0] = exp0; assign exp_v[1] = exp1; assign exp_v[2] = {1'b0, exp2};

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int m_cnt [NDUT][4];
  bit m_ovf [NDUT][4];
  bit m_arm [NDUT][4];
  bit m_exp [NDUT][4];

  function automatic int nregs_of(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic bit sat_of(int k);
    return (k == 1);
  endfunction

  function automatic int to_s(int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic logic [3:0] mvec_ovf(int k);
    return {m_ovf[k][3], m_ovf[k][2], m_ovf[k][1], m_ovf[k][0]};
  endfunction
  function automatic logic [3:0] mvec_arm(int k);
    return {m_arm[k][3], m_arm[k][2], m_arm[k][1], m_arm[k][0]};
  endfunction
  function automatic logic [3:0] mvec_exp(int k);
    return {m_exp[k][3], m_exp[k][2], m_exp[k][1], m_exp[k][0]};
  endfunction

  // Applies one clock edge's worth of behaviour using the inputs seen at that
  // edge.
  task automatic model_edge();
    int a, b, r;
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_exp[k][i] = 1'b0;
        if (!reset_n) begin
          m_cnt[k][i] = 0; m_ovf[k][i] = 1'b0; m_arm[k][i] = 1'b0;
        end else if (i < nregs_of(k)) begin
          if (op_valid && op != NOP && int'(op_addr) == i) begin
            case (op)
              LOAD: begin
                m_cnt[k][i] = int'(op_data);
                m_ovf[k][i] = 1'b0;
                if (m_cnt[k][i] == 0) m_arm[k][i] = 1'b0;
              end
              CLR: begin
                m_cnt[k][i] = 0; m_ovf[k][i] = 1'b0; m_arm[k][i] = 1'b0;
              end
              ARM: begin
                if (m_cnt[k][i] == 0) begin
                  m_arm[k][i] = 1'b0; m_exp[k][i] = 1'b1;
                end else begin
                  m_arm[k][i] = 1'b1;
                end
              end
              default: begin
                a = to_s(m_cnt[k][i]);
                b = (op == INC || op == DEC) ? 1 : to_s(int'(op_data));
                r = (op == INC || op == ADD) ? a + b : a - b;
                if (r > 127 || r < -128) begin
                  m_ovf[k][i] = 1'b1;
                  if (sat_of(k)) r = (r > 127) ? 127 : -128;
                end
                m_cnt[k][i] = r & 255;
                if (m_cnt[k][i] == 0) m_arm[k][i] = 1'b0;
              end
            endcase
            if (op != ARM && disarm[i]) m_arm[k][i] = 1'b0;
          end else if (disarm[i]) begin
            m_arm[k][i] = 1'b0;
          end else if (tick && m_arm[k][i]) begin
            m_cnt[k][i] = m_cnt[k][i] - 1;
            if (m_cnt[k][i] == 0) begin
              m_arm[k][i] = 1'b0; m_exp[k][i] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d,
                        input logic t, input logic [3:0] dis);
    op_valid = 1'b1; op = o; op_addr = a; op_data = d; tick = t; disarm = dis;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d,
                     input logic t, input logic [3:0] dis);
    set_in(o, a, d, t, dis);
    clk_edge();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    set_in(NOP, 2'd0, 8'h00, 1'b0, 4'b0000);
    clk_edge();
    clk_edge();
    for (int r = 0; r < 4; r++) begin
      rd_addr = r[1:0];
      #1;
      for (int k = 0; k < NDUT; k++) begin
        n_tests++;
        if (rd_v[k] !== 8'h00) begin
          n_fail++; $display("FAIL reset_cnt dut%0d r%0d: got %h want 00", k, r, rd_v[k]);
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      n_tests++;
      if (ovf_v[k] !== 4'h0 || arm_v[k] !== 4'h0 || exp_v[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_flags dut%0d: ovf=%b armed=%b expire=%b want all 0",
                 k, ovf_v[k], arm_v[k], exp_v[k]);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    cyc(LOAD, 2'd1, 8'h05, 1'b0, 4'b0000);
    cyc(ARM,  2'd1, 8'h00, 1'b0, 4'b0000);
    cyc(NOP,  2'd0, 8'h00, 1'b1, 4'b0000);
    cyc(NOP,  2'd0, 8'h00, 1'b1, 4'b0000);
    rd_addr = 2'd1;
    #1;
    n_tests++;
    if (rd_v[0] !== 8'h03 || arm_v[0][1] !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: cnt=%h armed=%b want 03 armed=1", rd_v[0], arm_v[0][1]);
    end
    reset_n = 1'b0;
    set_in(NOP, 2'd0, 8'h00, 1'b1, 4'b0000);
    clk_edge();
    n_tests++;
    if (rd_v[0] !== 8'h00 || arm_v[0] !== 4'h0 || exp_v[0] !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_reset: cnt=%h armed=%b expire=%b want 00/0000/0000", rd_v[0], arm_v[0], exp_v[0]);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc(NOP, 2'd0, 8'h00, 1'b1, 4'b0000);
      n_tests++;
      if (exp_v[0] !== 4'h0 || rd_v[0] !== 8'h00) begin
        n_fail++; $display("FAIL mid_no_expire c%0d: expire=%b cnt=%h want 0000/00", c, exp_v[0], rd_v[0]);
      end
    end
  endtask

  task automatic test_wrap();
    rd_addr = 2'd0;
    cyc(LOAD, 2'd0, 8'h7F, 1'b0, 4'b0000);
    cyc(INC,  2'd0, 8'h00, 1'b0, 4'b0000);
    n_tests++;
    if (rd_v[0] !== 8'h80 || neg_v[0] !== 1'b1 || ovf_v[0][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_inc: rd=%h neg=%b ovf=%b want 80/1/1", rd_v[0], neg_v[0], ovf_v[0][0]);
    end
    n_tests++;
    if (rd_v[1] !== 8'h7F || ovf_v[1][0] !== 1'b1) begin
      n_fail++; $display("FAIL sat_inc: rd=%h ovf=%b want 7f/1", rd_v[1], ovf_v[1][0]);
    end
    cyc(LOAD, 2'd0, 8'h10, 1'b0, 4'b0000);
    n_tests++;
    if (rd_v[0] !== 8'h10 || ovf_v[0][0] !== 1'b0 || pos_v[0] !== 1'b1 || neg_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_load: rd=%h ovf=%b pos=%b neg=%b want 10/0/1/0",
               rd_v[0], ovf_v[0][0], pos_v[0], neg_v[0]);
    end
  endtask

  task automatic test_saturation();
    rd_addr = 2'd2;
    cyc(LOAD, 2'd2, 8'h82, 1'b0, 4'b0000);
    cyc(SUB,  2'd2, 8'h05, 1'b0, 4'b0000);
    n_tests++;
    if (rd_v[1] !== 8'h80 || ovf_v[1][2] !== 1'b1) begin
      n_fail++; $display("FAIL sat_sub: rd=%h ovf=%b want 80/1", rd_v[1], ovf_v[1][2]);
    end
    n_tests++;
    if (rd_v[0] !== 8'h7D || ovf_v[0][2] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_sub: rd=%h ovf=%b want 7d/1", rd_v[0], ovf_v[0][2]);
    end
    cyc(ADD, 2'd2, 8'h7F, 1'b0, 4'b0000);
    n_tests++;
    if (rd_v[1] !== 8'hFF || neg_v[1] !== 1'b1 || ovf_v[1][2] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_add: rd=%h neg=%b ovf=%b want ff/1/1", rd_v[1], neg_v[1], ovf_v[1][2]);
    end
    n_tests++;
    if (rd_v[0] !== 8'hFC || ovf_v[0][2] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_add: rd=%h ovf=%b want fc/1", rd_v[0], ovf_v[0][2]);
    end
  endtask

  task automatic test_countdown();
    rd_addr = 2'd3;
    cyc(LOAD, 2'd3, 8'h03, 1'b0, 4'b0000);
    cyc(ARM,  2'd3, 8'h00, 1'b0, 4'b0000);
    for (int t = 1; t <= 3; t++) begin
      cyc(NOP, 2'd0, 8'h00, 1'b1, 4'b0000);
      n_tests++;
      if (rd_v[0] !== 8'(3 - t) || exp_v[0][3] !== (t == 3) || arm_v[0][3] !== (t != 3)) begin
        n_fail++;
        $display("FAIL countdown t%0d: rd=%h exp=%b armed=%b want %0d/%0d/%0d",
                 t, rd_v[0], exp_v[0][3], arm_v[0][3], 3 - t, (t == 3), (t != 3));
      end
    end
    cyc(NOP, 2'd0, 8'h00, 1'b1, 4'b0000);
    n_tests++;
    if (exp_v[0][3] !== 1'b0 || rd_v[0] !== 8'h00 || arm_v[0][3] !== 1'b0) begin
      n_fail++;
      $display("FAIL countdown_after: exp=%b rd=%h armed=%b want 0/00/0", exp_v[0][3], rd_v[0], arm_v[0][3]);
    end
  endtask

  task automatic test_collision();
    cyc(LOAD, 2'd0, 8'h05, 1'b0, 4'b0000);
    cyc(LOAD, 2'd1, 8'h05, 1'b0, 4'b0000);
    cyc(ARM,  2'd0, 8'h00, 1'b0, 4'b0000);
    cyc(ARM,  2'd1, 8'h00, 1'b0, 4'b0000);
    cyc(INC,  2'd0, 8'h00, 1'b1, 4'b0000);
    rd_addr = 2'd0; #1;
    n_tests++;
    if (rd_v[0] !== 8'h06) begin
      n_fail++; $display("FAIL coll_r0: got %h want 06", rd_v[0]);
    end
    rd_addr = 2'd1; #1;
    n_tests++;
    if (rd_v[0] !== 8'h04 || arm_v[0][1:0] !== 2'b11) begin
      n_fail++; $display("FAIL coll_r1: got %h armed=%b want 04/11", rd_v[0], arm_v[0][1:0]);
    end
    cyc(NOP, 2'd0, 8'h00, 1'b1, 4'b0010);
    n_tests++;
    if (rd_v[0] !== 8'h04 || arm_v[0][1] !== 1'b0 || exp_v[0] !== 4'h0) begin
      n_fail++;
      $display("FAIL disarm_r1: rd=%h armed=%b exp=%b want 04/0/0000", rd_v[0], arm_v[0][1], exp_v[0]);
    end
    rd_addr = 2'd0; #1;
    n_tests++;
    if (rd_v[0] !== 8'h05 || arm_v[0][0] !== 1'b1) begin
      n_fail++; $display("FAIL disarm_r0_ticks: got %h armed=%b want 05/1", rd_v[0], arm_v[0][0]);
    end
    cyc(NOP, 2'd0, 8'h00, 1'b1, 4'b0000);
    rd_addr = 2'd1; #1;
    n_tests++;
    if (rd_v[0] !== 8'h04 || exp_v[0] !== 4'h0) begin
      n_fail++; $display("FAIL disarm_hold: rd=%h exp=%b want 04/0000", rd_v[0], exp_v[0]);
    end
    cyc(CLR, 2'd0, 8'h00, 1'b0, 4'b0000);
  endtask

  task automatic test_edge();
    cyc(CLR, 2'd2, 8'h00, 1'b0, 4'b0000);
    cyc(ARM, 2'd2, 8'h00, 1'b0, 4'b0000);
    n_tests++;
    if (exp_v[0][2] !== 1'b1 || arm_v[0][2] !== 1'b0) begin
      n_fail++; $display("FAIL arm_zero: exp=%b armed=%b want 1/0", exp_v[0][2], arm_v[0][2]);
    end
    cyc(NOP, 2'd0, 8'h00, 1'b0, 4'b0000);
    n_tests++;
    if (exp_v[0][2] !== 1'b0) begin
      n_fail++; $display("FAIL arm_zero_pulse: exp=%b want 0", exp_v[0][2]);
    end
    cyc(LOAD, 2'd1, 8'h09, 1'b0, 4'b0000);
    cyc(ARM,  2'd1, 8'h00, 1'b0, 4'b0010);
    n_tests++;
    if (arm_v[0][1] !== 1'b1) begin
      n_fail++; $display("FAIL arm_beats_disarm: armed=%b want 1", arm_v[0][1]);
    end
    cyc(CLR,  2'd1, 8'h00, 1'b0, 4'b0000);
    // op_addr=3 exists on dut0 but is out of range on the 3-counter instance.
    cyc(LOAD, 2'd3, 8'h55, 1'b0, 4'b0000);
    cyc(ARM,  2'd3, 8'h00, 1'b0, 4'b0000);
    rd_addr = 2'd3; #1;
    n_tests++;
    if (rd_v[2] !== 8'h00 || zero_v[2] !== 1'b1 || arm_v[2] !== 4'h0) begin
      n_fail++;
      $display("FAIL oor_n3: rd=%h zero=%b armed=%b want 00/1/0000", rd_v[2], zero_v[2], arm_v[2]);
    end
    n_tests++;
    if (rd_v[0] !== 8'h55 || arm_v[0][3] !== 1'b1) begin
      n_fail++; $display("FAIL inrange_r3: rd=%h armed=%b want 55/1", rd_v[0], arm_v[0][3]);
    end
    for (int r = 0; r < 3; r++) begin
      rd_addr = r[1:0]; #1;
      n_tests++;
      if (rd_v[2] !== 8'(m_cnt[2][r])) begin
        n_fail++; $display("FAIL oor_nochange r%0d: got %h want %h", r, rd_v[2], 8'(m_cnt[2][r]));
      end
    end
    cyc(CLR, 2'd3, 8'h00, 1'b0, 4'b0000);
  endtask

  task automatic test_random();
    logic [7:0] exp_rd;
    reset_n = 1'b0;
    set_in(NOP, 2'd0, 8'h00, 1'b0, 4'b0000);
    clk_edge();
    reset_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      op_valid = ($urandom_range(0, 7) != 0);
      op       = ($urandom_range(0, 3) == 0) ? ARM : 3'($urandom_range(0, 7));
      op_addr  = 2'($urandom_range(0, 3));
      op_data  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      tick     = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 4; i++) disarm[i] = ($urandom_range(0, 9) == 0);
      rd_addr  = 2'($urandom_range(0, 3));
      clk_edge();
      for (int k = 0; k < NDUT; k++) begin
        exp_rd = (int'(rd_addr) < nregs_of(k)) ? 8'(m_cnt[k][rd_addr]) : 8'h00;
        n_tests++;
        if (rd_v[k] !== exp_rd || neg_v[k] !== exp_rd[7] || zero_v[k] !== (exp_rd == 8'h00) ||
            pos_v[k] !== (exp_rd != 8'h00 && !exp_rd[7])) begin
          n_fail++;
          $display("FAIL rand_rd c%0d dut%0d a%0d: rd=%h n=%b z=%b p=%b want rd=%h",
                   c, k, rd_addr, rd_v[k], neg_v[k], zero_v[k], pos_v[k], exp_rd);
        end
        n_tests++;
        if (ovf_v[k] !== mvec_ovf(k) || arm_v[k] !== mvec_arm(k) || exp_v[k] !== mvec_exp(k)) begin
          n_fail++;
          $display("FAIL rand_vec c%0d dut%0d: ovf=%b armed=%b exp=%b want %b/%b/%b",
                   c, k, ovf_v[k], arm_v[k], exp_v[k], mvec_ovf(k), mvec_arm(k), mvec_exp(k));
        end
      end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    rd_addr = 2'd0;
    set_in(NOP, 2'd0, 8'h00, 1'b0, 4'b0000);
    test_reset();
    test_reset_mid();
    test_wrap();
    test_saturation();
    test_countdown();
    test_collision();
    test_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
